// File: rtl/fft_power_peak.sv
// Per-bin power (re^2 + im^2) of packed complex FFT bins via a sequential shift-add squarer,
// with per-frame peak-bin and total-energy tracking for the display path.
module fft_power_peak #(
    parameter int WIDTH    = 16,
    parameter int NUM_BINS = 4,
    localparam int H  = WIDTH / 2,
    localparam int IW = $clog2(NUM_BINS),
    localparam int CW = $clog2(H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                pwr_valid,
    output logic [WIDTH-1:0]    pwr_data,
    output logic [IW-1:0]       pwr_bin,
    output logic                frame_done,
    output logic [IW-1:0]       peak_bin,
    output logic [WIDTH-1:0]    peak_pwr,
    output logic [WIDTH+IW-1:0] total_energy,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, SQ_RE, SQ_IM, EMIT, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bin_idx;
    logic [H-1:0]         re_mag;
    logic [H-1:0]         im_mag;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     run_peak;
    logic [IW-1:0]        run_peak_bin;
    logic [WIDTH+IW-1:0]  run_total;

    logic signed [H-1:0]  in_re;
    logic signed [H-1:0]  in_im;
    logic [H-1:0]         mag_cur;
    logic [WIDTH-1:0]     term;

    // Unsigned magnitude; the most negative value maps to 2^(H-1), which still fits in H bits.
    function automatic logic [H-1:0] mag_of(input logic signed [H-1:0] v);
        logic [H-1:0] u;
        u = v;
        return v[H-1] ? (~u + H'(1)) : u;
    endfunction

    assign in_re    = in_data[WIDTH-1:H];
    assign in_im    = in_data[H-1:0];
    assign in_ready = (state == IDLE) && en && !clr;
    assign busy     = (state != IDLE);

    // One partial product per cycle: add mag << cnt when bit cnt of the same magnitude is set.
    always_comb begin
        mag_cur = (state == SQ_IM) ? im_mag : re_mag;
        term    = '0;
        if (mag_cur[cnt])
            term = {{(WIDTH-H){1'b0}}, mag_cur} << cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bin_idx      <= '0;
            re_mag       <= '0;
            im_mag       <= '0;
            acc          <= '0;
            run_peak     <= '0;
            run_peak_bin <= '0;
            run_total    <= '0;
            pwr_valid    <= 1'b0;
            pwr_data     <= '0;
            pwr_bin      <= '0;
            frame_done   <= 1'b0;
            peak_bin     <= '0;
            peak_pwr     <= '0;
            total_energy <= '0;
        end else if (clr) begin
            // Abort the frame in progress; completed frame results are left untouched.
            state        <= IDLE;
            cnt          <= '0;
            bin_idx      <= '0;
            run_peak     <= '0;
            run_peak_bin <= '0;
            run_total    <= '0;
            pwr_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else if (en) begin
            pwr_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        re_mag <= mag_of(in_re);
                        im_mag <= mag_of(in_im);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= SQ_RE;
                    end
                end
                SQ_RE: begin
                    acc <= acc + term;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(H-1))
                        state <= SQ_IM;
                end
                SQ_IM: begin
                    acc <= acc + term;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(H-1))
                        state <= EMIT;
                end
                EMIT: begin
                    pwr_valid <= 1'b1;
                    pwr_data  <= acc;
                    pwr_bin   <= bin_idx;
                    run_total <= run_total + {{IW{1'b0}}, acc};
                    // Strict compare so equal powers keep the earlier bin.
                    if (acc > run_peak) begin
                        run_peak     <= acc;
                        run_peak_bin <= bin_idx;
                    end
                    if (bin_idx == IW'(NUM_BINS-1)) begin
                        state <= DONE;
                    end else begin
                        bin_idx <= bin_idx + IW'(1);
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    frame_done   <= 1'b1;
                    peak_bin     <= run_peak_bin;
                    peak_pwr     <= run_peak;
                    total_energy <= run_total;
                    run_peak     <= '0;
                    run_peak_bin <= '0;
                    run_total    <= '0;
                    bin_idx      <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak: bin powers, latency, frame peak/total, en freeze, clr abort, async reset.
module tb_fft_power_peak;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        pwr_valid;
    logic [15:0] pwr_data;
    logic [1:0]  pwr_bin;
    logic        frame_done;
    logic [1:0]  peak_bin;
    logic [15:0] peak_pwr;
    logic [17:0] total_energy;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fft_power_peak #(.WIDTH(16), .NUM_BINS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_bin(pwr_bin),
        .frame_done(frame_done), .peak_bin(peak_bin), .peak_pwr(peak_pwr),
        .total_energy(total_energy), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present a word and hold in_valid until the edge that accepts it; returns 1ns after that edge.
    task automatic xfer(input logic [15:0] d);
        int i;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (i == 50) chk("xfer_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Count edges from acceptance to pwr_valid, optionally dropping en over a window of edges.
    task automatic wait_pwr(input int off_at, input int on_at, output int edges, output bit ready_ok);
        edges    = -1;
        ready_ok = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (n == off_at) en = 1'b0;
            if (n == on_at)  en = 1'b1;
            if (pwr_valid) begin
                edges = n;
                break;
            end
            if (in_ready) ready_ok = 1'b0;
        end
    endtask

    task automatic do_bin(input string tag, input logic [15:0] d, input int exp_pwr, input int exp_bin);
        int e;
        bit ok;
        xfer(d);
        wait_pwr(0, 0, e, ok);
        in_valid = 1'b0;
        chk({tag, "_lat"}, e, 17);
        chk({tag, "_pwr"}, pwr_data, exp_pwr);
        chk({tag, "_bin"}, pwr_bin, exp_bin);
        chk({tag, "_rdylow"}, ok, 1);
    endtask

    task automatic chk_frame(input string tag, input int pb, input int pp, input int te);
        @(posedge clk);
        #1;
        chk({tag, "_fdone"}, frame_done, 1);
        chk({tag, "_pbin"}, peak_bin, pb);
        chk({tag, "_ppwr"}, peak_pwr, pp);
        chk({tag, "_tot"}, total_energy, te);
        @(posedge clk);
        #1;
        chk({tag, "_fdone_pulse"}, frame_done, 0);
    endtask

    initial begin
        int e;
        bit ok;

        // Reset state
        #12;
        chk("rst_pwr_valid", pwr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", total_energy, 0);
        chk("rst_peak", peak_pwr, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // Frame 1: (3,4)=25, (-128,-128)=32768, (0,0)=0, (1,1)=2
        do_bin("b34", 16'h0304, 25, 0);
        @(posedge clk);
        #1;
        chk("b34_once_busy", busy, 0);
        chk("b34_pulse", pwr_valid, 0);
        do_bin("bmin", 16'h8080, 32768, 1);
        do_bin("bzero", 16'h0000, 0, 2);
        do_bin("b11", 16'h0101, 2, 3);
        chk_frame("f1", 1, 32768, 32795);

        // Frame 2: powers 1, 25, 25, 8 -> tie keeps bin 1
        do_bin("f2b0", 16'h0100, 1, 0);
        do_bin("f2b1", 16'h0005, 25, 1);
        do_bin("f2b2", 16'hFB00, 25, 2);
        do_bin("f2b3", 16'h0202, 8, 3);
        chk_frame("f2", 1, 25, 59);

        // en low for 5 edges during SQ_IM stretches latency by 5
        xfer(16'h0304);
        wait_pwr(10, 15, e, ok);
        in_valid = 1'b0;
        chk("en_lat", e, 22);
        chk("en_pwr", pwr_data, 25);
        chk("en_bin", pwr_bin, 0);
        chk("en_rdylow", ok, 1);
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("en_idle_rdy0", in_ready, 0);
        en = 1'b1;
        #1;
        chk("en_idle_rdy1", in_ready, 1);
        do_bin("en_b1", 16'h0005, 25, 1);

        // clr with in_valid in IDLE: abort frame, no transfer
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0707;
        #1;
        chk("clr_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_no_xfer", busy, 0);
        chk("clr_keep_tot", total_energy, 59);
        repeat (2) @(posedge clk);
        #1;
        chk("clr_still_idle", busy, 0);

        // Fresh frame after clr: 1, 4, 0, 2
        do_bin("f3b0", 16'h0100, 1, 0);
        do_bin("f3b1", 16'h0002, 4, 1);
        do_bin("f3b2", 16'h0000, 0, 2);
        do_bin("f3b3", 16'hFFFF, 2, 3);
        chk_frame("f3", 1, 4, 7);

        // Async reset mid-SQ_RE
        xfer(16'h0304);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pwr", pwr_data, 0);
        chk("arst_bin", pwr_bin, 0);
        chk("arst_tot", total_energy, 0);
        chk("arst_peak", peak_pwr, 0);
        chk("arst_pbin", peak_bin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rdy", in_ready, 1);

        // Frame after reset: 13, 49, 36, 49 -> tie keeps bin 1
        do_bin("f4b0", 16'hFE03, 13, 0);
        do_bin("f4b1", 16'h00F9, 49, 1);
        do_bin("f4b2", 16'h0600, 36, 2);
        do_bin("f4b3", 16'h0700, 49, 3);
        chk_frame("f4", 1, 49, 147);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
